// File: rtl/mux_n_pipe.sv
// Registered N:1 datapath mux with a valid/ready output stage, flush, and
// out-of-range select detection feeding a saturating debug error counter.

module mux_n_pipe_lane #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 2,
    parameter int IDX    = 0
) (
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    // Each lane gates its word onto the OR-bus only when selected.
    assign dout = (sel == SEL_W'(IDX)) ? din : '0;
endmodule

module mux_n_pipe #(
    parameter int DATA_W = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sel_err,
    output logic [CNT_W-1:0]         err_cnt,
    input  logic                     err_clr
);
    localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
        $error("mux_n_pipe: NUM_IN must be in 2..16");
    end
    if ((2**SEL_W) < NUM_IN) begin : g_bad_sel_w
        $error("mux_n_pipe: SEL_W too narrow for NUM_IN");
    end

    logic [NUM_IN-1:0][DATA_W-1:0] lane_in, lane_out;
    logic [DATA_W-1:0]             mux_data;
    logic                          sel_ok, accept;

    assign lane_in = in_data;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_lane
        mux_n_pipe_lane #(.DATA_W(DATA_W), .SEL_W(SEL_W), .IDX(k)) u_lane (
            .sel  (sel),
            .din  (lane_in[k]),
            .dout (lane_out[k])
        );
    end

    // Out-of-range selects match no lane, so the OR-bus yields zero for free.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < NUM_IN; k++) mux_data = mux_data | lane_out[k];
    end

    assign sel_ok   = {1'b0, sel} < NUM_IN_W;
    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            sel_err   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            sel_err   <= !sel_ok;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Clear wins over a same-cycle increment; count sticks at all-ones.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            err_cnt <= '0;
        else if (err_clr)
            err_cnt <= '0;
        else if (accept && !sel_ok && err_cnt != {CNT_W{1'b1}})
            err_cnt <= err_cnt + 1'b1;
    end
endmodule

// File: tb/tb_mux_n_pipe.sv
// Randomized + directed bench for mux_n_pipe against a queue-based stage model.

module tb_mux_n_pipe;
    localparam int DATA_W = 16;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     arst_n = 1'b0;
    logic [NUM_IN*DATA_W-1:0] in_data = '0;
    logic [SEL_W-1:0]         sel = '0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic                     flush = 1'b0;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic                     sel_err;
    logic [CNT_W-1:0]         err_cnt;
    logic                     err_clr = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              e;
    } word_t;

    word_t q[$];
    int    m_cnt = 0;

    mux_n_pipe #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .arst_n(arst_n), .in_data(in_data), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sel_err(sel_err), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage is a queue of depth 0/1; err count is plain saturating arithmetic.
    always @(negedge arst_n) begin
        q.delete();
        m_cnt = 0;
    end

    always @(posedge clk) begin
        if (arst_n) begin
            bit acc;
            word_t w;
            acc = in_valid && !flush && (q.size() == 0 || out_ready);
            if (flush) q.delete();
            else begin
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                if (acc) begin
                    if (int'(sel) < NUM_IN) begin
                        w.d = in_data[int'(sel)*DATA_W +: DATA_W];
                        w.e = 1'b0;
                    end else begin
                        w.d = '0;
                        w.e = 1'b1;
                    end
                    q.push_back(w);
                end
            end
            if (err_clr) m_cnt = 0;
            else if (acc && int'(sel) >= NUM_IN && m_cnt < CMAX) m_cnt++;
        end
    end

    always @(negedge clk) begin
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("in_ready", 64'(in_ready), 64'(!flush && (q.size() == 0 || out_ready)));
        check("err_cnt", 64'(err_cnt), 64'(m_cnt));
        if (q.size() != 0) begin
            check("out_data", 64'(out_data), 64'(q[0].d));
            check("sel_err", 64'(sel_err), 64'(q[0].e));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_fixed();
        in_data = {16'h3333, 16'h2222, 16'h1111};
    endtask

    initial begin
        load_fixed();
        step();
        step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_err", 64'(sel_err), 64'd0);
        check("rst_cnt", 64'(err_cnt), 64'd0);
        arst_n = 1'b1;

        // Basic select
        out_ready = 1'b1; in_valid = 1'b1; sel = 2'd2;
        step();
        check("s1_valid", 64'(out_valid), 64'd1);
        check("s1_data", 64'(out_data), 64'h3333);
        check("s1_err", 64'(sel_err), 64'd0);
        in_valid = 1'b0;
        step();

        // Out-of-range and saturation
        in_valid = 1'b1; sel = 2'd3;
        step();
        check("s2_data", 64'(out_data), 64'h0);
        check("s2_err", 64'(sel_err), 64'd1);
        check("s2_cnt1", 64'(err_cnt), 64'd1);
        for (int i = 1; i < 300; i++) step();
        check("s2_sat", 64'(err_cnt), 64'd255);
        err_clr = 1'b1;
        step();
        check("s2_clr", 64'(err_cnt), 64'd0);
        err_clr = 1'b0; in_valid = 1'b0;
        step();

        // Backpressure
        in_valid = 1'b1; sel = 2'd1;
        step();
        check("s3_first", 64'(out_data), 64'h2222);
        out_ready = 1'b0; sel = 2'd0;
        for (int i = 0; i < 5; i++) begin
            #1 check("s3_rdy", 64'(in_ready), 64'd0);
            step();
            check("s3_hold", 64'(out_data), 64'h2222);
            check("s3_hvld", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        step();
        check("s3_next", 64'(out_data), 64'h1111);
        in_valid = 1'b0;
        step();

        // Streaming
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = SEL_W'(i);
            step();
            check("s4_vld", 64'(out_valid), 64'd1);
            check("s4_data", 64'(out_data), (i == 0) ? 64'h1111 : (i == 1) ? 64'h2222 :
                                            (i == 2) ? 64'h3333 : 64'h0);
        end
        in_valid = 1'b0;
        step();

        // Flush
        flush = 1'b1; in_valid = 1'b1; sel = 2'd3;
        #1 check("s5_rdy", 64'(in_ready), 64'd0);
        step();
        check("s5_vld", 64'(out_valid), 64'd0);
        check("s5_cnt", 64'(err_cnt), 64'd1);
        flush = 1'b0; sel = 2'd2; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        check("s5_stall", 64'(out_valid), 64'd1);
        flush = 1'b1;
        step();
        check("s5_kill", 64'(out_valid), 64'd0);
        flush = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            in_data   = {16'($urandom), 16'($urandom), 16'($urandom)};
            sel       = SEL_W'($urandom_range(0, 3));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            err_clr   = ($urandom_range(0, 63) == 0);
            step();
        end
        flush = 1'b0; err_clr = 1'b0;

        // Mid-stream async reset
        load_fixed();
        in_valid = 1'b1; out_ready = 1'b1; sel = 2'd3;
        step();
        step();
        #2 arst_n = 1'b0;
        #1;
        check("s6_valid", 64'(out_valid), 64'd0);
        check("s6_data", 64'(out_data), 64'd0);
        check("s6_err", 64'(sel_err), 64'd0);
        check("s6_cnt", 64'(err_cnt), 64'd0);
        step();
        arst_n = 1'b1; sel = 2'd2;
        step();
        check("s6_vld2", 64'(out_valid), 64'd1);
        check("s6_data2", 64'(out_data), 64'h3333);
        check("s6_err2", 64'(sel_err), 64'd0);
        in_valid = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
